// File: rtl/timestamp_capture_pkg.sv
// Shared constants for the timestamp capture block and its consumers.
// An entry is {wrap_flag, timestamp}; the flag sits directly above the timestamp field.
package timestamp_capture_pkg;

  localparam int unsigned TS_WIDTH    = 4;
  localparam int unsigned ENTRY_WIDTH = TS_WIDTH + 1;
  localparam int unsigned TS_LSB      = 0;
  localparam int unsigned WRAP_BIT    = TS_WIDTH;

  function automatic int unsigned entry_width(input int unsigned ts_width);
    return ts_width + 1;
  endfunction

  function automatic int unsigned wrap_bit_pos(input int unsigned ts_width);
    return ts_width;
  endfunction

endpackage

// File: rtl/timestamp_capture_sync_fifo.sv
// First-word-fall-through synchronous FIFO with an occupancy count.
// A push into a full FIFO is still accepted when a pop happens on the same edge.
module sync_fifo #(
  parameter int G_DATA_WIDTH = 5,
  parameter int G_DEPTH      = 4,
  localparam int FILL_W      = $clog2(G_DEPTH + 1),
  localparam int PTR_W       = $clog2(G_DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  logic [G_DATA_WIDTH-1:0] push_data,
  input  logic                    pop,
  output logic                    push_ok,
  output logic                    pop_ok,
  output logic [G_DATA_WIDTH-1:0] pop_data,
  output logic [FILL_W-1:0]       fill,
  output logic                    full,
  output logic                    empty
);

  logic [G_DATA_WIDTH-1:0] mem_q [G_DEPTH];
  logic [G_DATA_WIDTH-1:0] mem_d [G_DEPTH];
  logic [PTR_W-1:0]        head_q, head_d;
  logic [PTR_W-1:0]        tail_q, tail_d;
  logic [FILL_W-1:0]       fill_q, fill_d;

  always_comb begin
    empty   = (fill_q == '0);
    full    = (fill_q == FILL_W'(G_DEPTH));
    pop_ok  = pop & ~empty;
    push_ok = push & (~full | pop_ok);

    head_d = head_q + PTR_W'(pop_ok);
    tail_d = tail_q + PTR_W'(push_ok);

    unique case ({push_ok, pop_ok})
      2'b10:   fill_d = fill_q + FILL_W'(1);
      2'b01:   fill_d = fill_q - FILL_W'(1);
      default: fill_d = fill_q;
    endcase

    mem_d = mem_q;
    if (push_ok) begin
      mem_d[tail_q] = push_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
      fill_q <= '0;
      for (int i = 0; i < G_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      fill_q <= fill_d;
      mem_q  <= mem_d;
    end
  end

  // Outputs read zero when empty so consumers never see stale entries.
  assign pop_data = empty ? '0 : mem_q[head_q];
  assign fill     = fill_q;

endmodule

// File: rtl/timestamp_capture.sv
// Timestamps rising edges of event_in with count_in and queues {wrap_flag, timestamp}.
// The wrap flag marks any counter decrease since the previous accepted capture.
module timestamp_capture
  import timestamp_capture_pkg::*;
#(
  parameter int G_WIDTH = TS_WIDTH,
  parameter int G_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [G_WIDTH-1:0]             count_in,
  input  logic                           event_in,
  output logic [G_WIDTH:0]               out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [$clog2(G_DEPTH+1)-1:0]   fill,
  output logic                           overflow
);

  localparam int EW = entry_width(G_WIDTH);

  logic               event_q, event_d;
  logic [G_WIDTH-1:0] prev_count_q, prev_count_d;
  logic               wrap_pend_q, wrap_pend_d;
  logic               overflow_q, overflow_d;

  logic               rise;
  logic               wrap;
  logic [EW-1:0]      entry;
  logic               push_ok;
  logic               pop_ok;
  logic               fifo_full;
  logic               fifo_empty;

  always_comb begin
    rise  = event_in & ~event_q;
    wrap  = (count_in < prev_count_q);
    entry = {wrap_pend_q | wrap, count_in};

    event_d      = event_in;
    prev_count_d = count_in;

    // A dropped capture keeps the pending wrap so the next accepted entry still reports it.
    if (push_ok) begin
      wrap_pend_d = 1'b0;
    end else begin
      wrap_pend_d = wrap_pend_q | wrap;
    end

    overflow_d = overflow_q | (rise & ~push_ok);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      event_q      <= 1'b0;
      prev_count_q <= '0;
      wrap_pend_q  <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      event_q      <= event_d;
      prev_count_q <= prev_count_d;
      wrap_pend_q  <= wrap_pend_d;
      overflow_q   <= overflow_d;
    end
  end

  sync_fifo #(
    .G_DATA_WIDTH (EW),
    .G_DEPTH      (G_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (rise),
    .push_data (entry),
    .pop       (out_ready),
    .push_ok   (push_ok),
    .pop_ok    (pop_ok),
    .pop_data  (out_data),
    .fill      (fill),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign out_valid = ~fifo_empty;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_timestamp_capture.sv
// Self-checking bench for timestamp_capture: queue-based reference model compared every
// negedge, plus directed scenarios with hand-computed expectations.
module tb_timestamp_capture;

  localparam int DEPTH = 4;

  logic       clk;
  logic       reset;
  logic [3:0] count_in;
  logic       event_in;
  logic [4:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] fill;
  logic       overflow;

  int checks;
  int failures;

  timestamp_capture #(
    .G_WIDTH (4),
    .G_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .count_in  (count_in),
    .event_in  (event_in),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .fill      (fill),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a plain queue of entries plus the few flags the behaviour depends on.
  logic [4:0] model_q [$];
  logic       m_evt;
  logic [3:0] m_prev;
  logic       m_wrap_pend;
  logic       m_overflow;
  logic       m_wrap;
  logic       m_rise;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      model_q.delete();
      m_evt       = 1'b0;
      m_prev      = 4'd0;
      m_wrap_pend = 1'b0;
      m_overflow  = 1'b0;
    end else begin
      m_wrap = (count_in < m_prev);
      m_rise = event_in && !m_evt;
      if (out_ready && model_q.size() > 0) begin
        void'(model_q.pop_front());
      end
      if (m_rise) begin
        if (model_q.size() < DEPTH) begin
          model_q.push_back({m_wrap_pend | m_wrap, count_in});
          m_wrap_pend = 1'b0;
        end else begin
          m_overflow  = 1'b1;
          m_wrap_pend = m_wrap_pend | m_wrap;
        end
      end else begin
        m_wrap_pend = m_wrap_pend | m_wrap;
      end
      m_evt  = event_in;
      m_prev = count_in;
    end
  end

  // Compare every output against the model in the middle of each cycle.
  always @(negedge clk) begin
    logic [4:0] exp_data;
    int         exp_fill;
    exp_fill = model_q.size();
    exp_data = (exp_fill > 0) ? model_q[0] : 5'd0;

    checks++;
    if (out_valid !== (exp_fill > 0)) begin
      failures++;
      $display("[TB] FAIL model_valid t=%0t got=%0b exp=%0b", $time, out_valid, exp_fill > 0);
    end
    checks++;
    if (out_data !== exp_data) begin
      failures++;
      $display("[TB] FAIL model_data t=%0t got=0x%02h exp=0x%02h", $time, out_data, exp_data);
    end
    checks++;
    if (int'(fill) != exp_fill || $isunknown(fill)) begin
      failures++;
      $display("[TB] FAIL model_fill t=%0t got=%0d exp=%0d", $time, fill, exp_fill);
    end
    checks++;
    if (overflow !== m_overflow) begin
      failures++;
      $display("[TB] FAIL model_overflow t=%0t got=%0b exp=%0b", $time, overflow, m_overflow);
    end
  end

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s got=0x%0h exp=0x%0h", name, actual, expected);
    end
  endtask

  // Apply one cycle of inputs, let the edge sample them, and return just after it.
  task automatic tick(input logic ev, input logic rdy, input logic [3:0] cnt);
    event_in  = ev;
    out_ready = rdy;
    count_in  = cnt;
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    event_in  = 1'b0;
    out_ready = 1'b0;
    count_in  = 4'd0;
    reset     = 1'b1;
    @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  logic [3:0] cnt;

  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    event_in  = 1'b0;
    out_ready = 1'b0;
    count_in  = 4'd0;
    repeat (2) @(posedge clk);
    #2;
    check_output("reset_valid", int'(out_valid), 0);
    check_output("reset_data", int'(out_data), 0);
    check_output("reset_fill", int'(fill), 0);
    check_output("reset_overflow", int'(overflow), 0);
    reset = 1'b0;

    // Single event at count 5
    do_reset();
    for (int c = 0; c <= 5; c++) tick(c == 5, 1'b0, 4'(c));
    check_output("single_valid", int'(out_valid), 1);
    check_output("single_data", int'(out_data), 'h05);
    check_output("single_fill", int'(fill), 1);
    tick(1'b0, 1'b0, 4'd6);

    // Wrap flag: 14, wrap, 2, then 6
    do_reset();
    for (int c = 10; c <= 15; c++) tick(c == 14, 1'b0, 4'(c));
    for (int c = 0; c <= 6; c++) tick(c == 2 || c == 6, 1'b0, 4'(c));
    check_output("wrap_fill", int'(fill), 3);
    check_output("wrap_head0", int'(out_data), 'h0E);
    tick(1'b0, 1'b1, 4'd7);
    check_output("wrap_head1", int'(out_data), 'h12);
    tick(1'b0, 1'b1, 4'd8);
    check_output("wrap_head2", int'(out_data), 'h06);
    tick(1'b0, 1'b1, 4'd9);
    check_output("wrap_empty", int'(out_valid), 0);

    // Overflow: five captures without draining
    do_reset();
    for (int c = 1; c <= 10; c++) tick(c[0], 1'b0, 4'(c));
    check_output("ovf_fill", int'(fill), 4);
    check_output("ovf_flag", int'(overflow), 1);
    for (int k = 0; k < 4; k++) begin
      check_output("ovf_drain", int'(out_data), 2 * k + 1);
      tick(1'b0, 1'b1, 4'(11 + k));
    end
    check_output("ovf_drained", int'(out_valid), 0);
    check_output("ovf_sticky", int'(overflow), 1);

    // Simultaneous push and pop while full
    do_reset();
    for (int c = 1; c <= 8; c++) tick(c[0], 1'b0, 4'(c));
    check_output("pp_full", int'(fill), 4);
    tick(1'b1, 1'b1, 4'd9);
    check_output("pp_fill", int'(fill), 4);
    check_output("pp_head", int'(out_data), 'h03);
    check_output("pp_overflow", int'(overflow), 0);
    for (int k = 0; k < 4; k++) begin
      check_output("pp_drain", int'(out_data), 2 * k + 3);
      tick(1'b0, 1'b1, 4'(10 + k));
    end

    // Counter reset treated as a wrap
    do_reset();
    for (int c = 5; c <= 9; c++) tick(1'b0, 1'b0, 4'(c));
    for (int c = 0; c <= 3; c++) tick(c == 3, 1'b0, 4'(c));
    check_output("cntrst_data", int'(out_data), 'h13);

    // Asynchronous reset mid-stream, event already high at release
    do_reset();
    tick(1'b1, 1'b0, 4'd1);
    tick(1'b0, 1'b0, 4'd2);
    tick(1'b1, 1'b0, 4'd3);
    tick(1'b0, 1'b0, 4'd4);
    tick(1'b1, 1'b0, 4'd5);
    check_output("async_pre_fill", int'(fill), 3);
    reset = 1'b1;
    #1;
    check_output("async_valid", int'(out_valid), 0);
    check_output("async_fill", int'(fill), 0);
    check_output("async_data", int'(out_data), 0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    tick(1'b1, 1'b0, 4'd4);
    check_output("async_recap_fill", int'(fill), 1);
    check_output("async_recap_data", int'(out_data), 'h04);

    // Randomized traffic against the model, with occasional counter resets
    do_reset();
    cnt = 4'd0;
    for (int i = 0; i < 800; i++) begin
      if (i == 400) begin
        do_reset();
      end
      if ($urandom_range(31) == 0) cnt = 4'd0;
      else cnt = cnt + 4'd1;
      tick(1'($urandom_range(1)), $urandom_range(9) < 4, cnt);
    end
    tick(1'b0, 1'b0, cnt);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
